// File: rtl/mru_pkg.sv
// Shared types and constants for the MRU push arbiter.
// Button count, code width, FSM states, index-to-code helper.
package mru_pkg;

    localparam int NUM_BTN = 4;
    localparam int IDX_W   = 2;
    localparam int ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        GAP
    } arb_state_t;

    function automatic logic [ID_W-1:0] idx_to_code(
        input logic [IDX_W-1:0] idx
    );
        return ID_W'(idx) + ID_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop sync, tick-based debounce, rise pulse.
// Ports: clk, rst (async low), tick, btn -> rise (1 cycle).
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic rise
);

    localparam int CW =
        (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [1:0]    sync;
    logic          synced;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    assign synced = sync[1];

    // Stable value flips on this tick.
    assign accept = tick && (synced != stable) && (cnt == LAST);
    assign rise   = accept && synced;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (tick) begin
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mru_push_arbiter.sv
// Debounced 4-button press capture, arbitration and push handshake.
// Ports: clk, rst (async low), btn[3:0], push_ready ->
//   push_valid, push_id[2:0], pending[3:0], busy.
// Macro MRU_ARB_ROUND_ROBIN_EN selects round-robin; else fixed priority.
module mru_push_arbiter
    import mru_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    output logic               push_valid,
    output logic [ID_W-1:0]    push_id,
    input  logic               push_ready,
    output logic [NUM_BTN-1:0] pending,
    output logic               busy
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] clr;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   win_q;
    logic               hs;
    logic               gap_armed;
    arb_state_t         state_q;
    arb_state_t         state_d;

    assign tick = (tick_cnt == TLAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .btn  (btn[g]),
            .rise (rise[g])
        );
    end

`ifdef MRU_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            idx = rr_ptr + IDX_W'(k);
            if (!found && pending[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= win_q + IDX_W'(1);
        end
    end
`else
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!found && pending[i]) begin
                win   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
`endif

    assign hs   = (state_q == OFFER) && push_ready;
    assign busy = (state_q != IDLE);

    always_comb begin
        clr = '0;
        if (hs) begin
            clr[win_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|pending) begin
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (push_ready) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                // Ignore a tick in the first GAP cycle.
                if (gap_armed && tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pending    <= '0;
            win_q      <= '0;
            push_valid <= 1'b0;
            push_id    <= '0;
            gap_armed  <= 1'b0;
        end else begin
            state_q   <= state_d;
            // New press beats a same-cycle clear.
            pending   <= (pending & ~clr) | rise;
            gap_armed <= (state_q == GAP);
            if (state_q == IDLE && (|pending)) begin
                win_q      <= win;
                push_valid <= 1'b1;
                push_id    <= idx_to_code(win);
            end
            if (hs) begin
                push_valid <= 1'b0;
                push_id    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mru_push_arbiter.sv
// Self-checking bench for mru_push_arbiter (TICK_DIV=4, DEBOUNCE_TICKS=2).
// Randomized presses checked against a grant-order reference model.
module tb_mru_push_arbiter;

    localparam int TD = 4;
    localparam int DT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       push_valid;
    logic [2:0] push_id;
    logic       push_ready;
    logic [3:0] pending;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int mptr    = 0;
    int got[$];
    int got_cyc[$];
    int exp_q[$];

    logic       prev_stall = 1'b0;
    logic [2:0] prev_id    = '0;

    mru_push_arbiter #(
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .push_valid (push_valid),
        .push_id    (push_id),
        .push_ready (push_ready),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Protocol monitor and handshake recorder.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (push_valid !== 1'b1) begin
                vectors++;
                if (push_id !== 3'd0) begin
                    errors++;
                    $display("FAIL idle_id: push_id=%0d, required 0",
                             push_id);
                end
            end
            if (prev_stall) begin
                vectors++;
                if (push_valid !== 1'b1 || push_id !== prev_id) begin
                    errors++;
                    $display("FAIL hold: valid=%b id=%0d, required 1/%0d",
                             push_valid, push_id, prev_id);
                end
            end
            if (push_valid === 1'b1 && push_ready === 1'b1) begin
                got.push_back(int'(push_id));
                got_cyc.push_back(cyc);
            end
            prev_stall = (push_valid === 1'b1) && (push_ready !== 1'b1);
            prev_id    = push_id;
        end
    end

    // Reference: buttons pending together are granted in search
    // order starting at the pointer (always 0 for fixed priority).
    task automatic model_grant(input logic [3:0] s);
        int p;
        int i;
        p = 0;
`ifdef MRU_ARB_ROUND_ROBIN_EN
        p = mptr;
`endif
        for (int k = 0; k < 4; k++) begin
            i = (p + k) % 4;
            if (s[i]) begin
                exp_q.push_back(i + 1);
                mptr = (i + 1) % 4;
            end
        end
    endtask

    task automatic clear_sb();
        got.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn        = 4'h0;
        push_ready = 1'b1;
        rst        = 1'b0;
        tick_n(5);
        rst  = 1'b1;
        mptr = 0;
        tick_n(2);
    endtask

    task automatic wait_pushes(input int n, input string name);
        int c;
        c = 0;
        while (got.size() < n && c < 400) begin
            tick_n(1);
            c++;
        end
        vectors++;
        if (got.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: pushes=%0d, required %0d",
                     name, got.size(), n);
        end
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (push_valid !== 1'b1 && c < 100) begin
            tick_n(1);
            c++;
        end
        vectors++;
        if (push_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: push_valid=%b, required 1",
                     name, push_valid);
        end
    endtask

    task automatic check_pushes(input string name);
        int n;
        vectors++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: pushes=%0d, required %0d",
                     name, got.size(), exp_q.size());
        end
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (got[i] != exp_q[i]) begin
                errors++;
                $display("FAIL %s_id[%0d]: push_id=%0d, required %0d",
                         name, i, got[i], exp_q[i]);
            end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            vectors++;
            if (got_cyc[i] - got_cyc[i-1] < TD) begin
                errors++;
                $display("FAIL %s_gap[%0d]: spacing=%0d, required >=%0d",
                         name, i, got_cyc[i] - got_cyc[i-1], TD);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        clear_sb();
        btn        = 4'hf;
        push_ready = 1'b1;
        rst        = 1'b0;
        tick_n(5);
        vectors += 4;
        if (push_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: %b, required 0", push_valid);
        end
        if (push_id !== 3'd0) begin
            errors++;
            $display("FAIL rst_id: %0d, required 0", push_id);
        end
        if (pending !== 4'h0) begin
            errors++;
            $display("FAIL rst_pending: %b, required 0000", pending);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: %b, required 0", busy);
        end
        rst  = 1'b1;
        mptr = 0;
        n    = 0;
        while (pending === 4'h0 && n < 40) begin
            tick_n(1);
            n++;
        end
        vectors += 2;
        if (pending !== 4'hf) begin
            errors++;
            $display("FAIL rst_first_pending: %b, required 1111", pending);
        end
        if (n < 2 + (DT - 1) * TD || n > 2 + (DT + 1) * TD + 2) begin
            errors++;
            $display("FAIL rst_latency: %0d cycles, required %0d..%0d",
                     n, 2 + (DT - 1) * TD, 2 + (DT + 1) * TD + 2);
        end
        model_grant(4'hf);
        wait_pushes(4, "rst_drain");
        check_pushes("rst_drain");
        btn = 4'h0;
        tick_n(30);
    endtask

    task automatic test_single_press();
        clear_sb();
        btn = 4'b0100;
        model_grant(4'b0100);
        wait_pushes(1, "single1");
        tick_n(2);
        vectors++;
        if (pending !== 4'h0) begin
            errors++;
            $display("FAIL single_pending: %b, required 0000", pending);
        end
        btn = 4'h0;
        tick_n(30);
        btn = 4'b0100;
        model_grant(4'b0100);
        wait_pushes(2, "single2");
        check_pushes("single");
        btn = 4'h0;
        tick_n(30);
    endtask

    task automatic test_glitch();
        clear_sb();
        btn = 4'b0010;
        tick_n(3);
        btn = 4'h0;
        tick_n(40);
        vectors += 2;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL glitch_push: pushes=%0d, required 0", got.size());
        end
        if (pending !== 4'h0) begin
            errors++;
            $display("FAIL glitch_pending: %b, required 0000", pending);
        end
    endtask

    task automatic test_stall_all();
        do_reset();
        clear_sb();
        push_ready = 1'b0;
        btn        = 4'hf;
        wait_valid("stall");
        vectors += 2;
        if (push_id !== 3'd1) begin
            errors++;
            $display("FAIL stall_id: %0d, required 1", push_id);
        end
        if (pending !== 4'hf) begin
            errors++;
            $display("FAIL stall_pending: %b, required 1111", pending);
        end
        for (int i = 0; i < 3 * TD; i++) begin
            tick_n(1);
            vectors++;
            if (push_valid !== 1'b1 || push_id !== 3'd1) begin
                errors++;
                $display("FAIL stall_hold: valid=%b id=%0d, required 1/1",
                         push_valid, push_id);
            end
        end
        push_ready = 1'b1;
        model_grant(4'hf);
        wait_pushes(4, "stall_drain");
        check_pushes("stall_drain");
        btn = 4'h0;
        tick_n(30);
    endtask

    task automatic test_rr_fairness();
        clear_sb();
        btn = 4'b1000;
        model_grant(4'b1000);
        wait_pushes(1, "rr4");
        btn = 4'h0;
        tick_n(30);
        push_ready = 1'b0;
        btn        = 4'b0101;
        model_grant(4'b0101);
        wait_valid("rr13");
        push_ready = 1'b1;
        tick_n(1);
        push_ready = 1'b0;
        btn = 4'b0100;
        tick_n(30);
        btn = 4'b0101;
        while (pending[0] !== 1'b1 && got.size() < 10 && cyc < 100000) begin
            tick_n(1);
            if (cyc % 200 == 0) break;
        end
        vectors++;
        if (pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL rr_repress: pending=%b, required bit0 set",
                     pending);
        end
        model_grant(4'b0001);
        push_ready = 1'b1;
        wait_pushes(4, "rr");
        check_pushes("rr");
        btn = 4'h0;
        tick_n(30);
    endtask

    task automatic test_reset_mid_offer();
        clear_sb();
        push_ready = 1'b0;
        btn        = 4'b0010;
        wait_valid("midrst");
        #2;
        rst = 1'b0;
        #1;
        vectors += 4;
        if (push_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: %b, required 0", push_valid);
        end
        if (push_id !== 3'd0) begin
            errors++;
            $display("FAIL midrst_id: %0d, required 0", push_id);
        end
        if (pending !== 4'h0) begin
            errors++;
            $display("FAIL midrst_pending: %b, required 0000", pending);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy: %b, required 0", busy);
        end
        btn = 4'h0;
        tick_n(3);
        rst        = 1'b1;
        mptr       = 0;
        push_ready = 1'b1;
        tick_n(40);
        vectors++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL midrst_residual: pushes=%0d, required 0",
                     got.size());
        end
    endtask

    task automatic test_random();
        logic [3:0] s;
        int c;
        for (int r = 0; r < 12; r++) begin
            clear_sb();
            s   = 4'($urandom_range(1, 15));
            btn = s;
            model_grant(s);
            c = 0;
            while (got.size() < exp_q.size() && c < 400) begin
                push_ready = 1'($urandom_range(0, 1));
                tick_n(1);
                c++;
            end
            push_ready = 1'b1;
            wait_pushes(exp_q.size(), "rand");
            check_pushes("rand");
            btn = 4'h0;
            tick_n(30);
            vectors += 2;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_extra: pushes=%0d, required %0d",
                         got.size(), exp_q.size());
            end
            if (pending !== 4'h0) begin
                errors++;
                $display("FAIL rand_pending: %b, required 0000", pending);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        btn        = 4'h0;
        push_ready = 1'b1;
        test_reset();
        test_single_press();
        test_glitch();
        test_stall_all();
        test_rr_fairness();
        test_reset_mid_offer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mru_push_arbiter.md
# mru_push_arbiter

Input-side controller for the most-recently-used LED stack. It samples four raw push-buttons, debounces them on a divided tick, and records each new press as a pending request. When several presses are pending, it arbitrates between them and issues exactly one push per handshake, as a 3-bit button code (1..4), toward the MRU stack datapath. It replaces the free-running timer and the direct button wiring in front of the stack.

## Interface
- `TICK_DIV`, default 50000: clk cycles per sample tick; legal range ≥ 2.
- `DEBOUNCE_TICKS`, default 4: consecutive ticks a changed input must persist before it is accepted; legal range ≥ 1.
- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `btn` in 4: raw buttons, asynchronous; `btn[0]`=button 1 … `btn[3]`=button 4.
- `push_valid` out 1: a push request is offered.
- `push_id` out 3: button code 1..4 while `push_valid`=1; 0 otherwise.
- `push_ready` in 1: the stack accepts the push.
- `pending` out 4: press-pending flags, registered.
- `busy` out 1: FSM is not in IDLE.

## Operation
- **Tick generator.** The counter runs 0..TICK_DIV-1 and wraps to 0. `tick` is a 1-cycle pulse in the cycle the count is TICK_DIV-1.
- **Synchroniser.** Each `btn` bit passes through a 2-flop synchroniser.
- **Debounce, per button, evaluated on tick only.**
  - If the synced input equals the stable value, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_TICKS-1 on a mismatching tick, the stable value takes the synced input and the counter clears.
- **Press capture.**
  - A rising edge of a stable value sets `pending[i]`.
  - Falling edges are ignored.
  - A press on a button already pending is merged into the existing flag.
- **Arbitration** chooses a winner among the `pending` bits; the mode is selected by the macro under Configuration.
- **FSM.**
  - **IDLE**: if `pending`≠0, register the winner, assert `push_valid`, drive `push_id`=winner+1, and go to OFFER.
  - **OFFER**: hold `push_valid` and `push_id` stable. When `push_ready`=1, the handshake completes. In that cycle clear `pending[winner]`, update the round-robin pointer to (winner+1) mod 4, drop `push_valid` and zero `push_id` on the next edge, and go to GAP.
  - **GAP**: wait for the next `tick`, then go to IDLE. This limits the stack to at most one push per tick.
- `busy` = (state≠IDLE).

## Timing
- **Reset values:** `push_valid`=0, `push_id`=0, `pending`=0, `busy`=0. The tick counter, synchronisers, debounce counters, stable values and round-robin pointer are all 0. The FSM is in IDLE.
- **Asynchronous reset:** assertion takes effect immediately, including mid-OFFER, where `push_valid` drops without a handshake.
- **Press latency:** synchroniser (2 cycles) plus DEBOUNCE_TICKS ticks, then `pending` is set 1 cycle after the accepting tick.
- **Grant latency:** pending set → `push_valid` high after 1 cycle.
- **Ready/valid rules:**
  - `push_ready` while `push_valid`=0 is ignored.
  - `push_ready` held high completes the handshake in the first OFFER cycle.
- **Simultaneous set and clear:** if a new press sets the same bit that is being cleared by a handshake in the same cycle, set wins and `pending[i]` stays 1.
- **Tick during GAP entry:** a tick arriving in the same cycle GAP is entered does not count. GAP waits for a later tick.

## Configuration
- **`MRU_ARB_ROUND_ROBIN_EN` defined:** round-robin arbitration. The search starts at the pointer and proceeds upward mod 4. The pointer advances only on a completed handshake.
- **`MRU_ARB_ROUND_ROBIN_EN` undefined:** fixed priority, `btn[0]` highest down to `btn[3]` lowest. The pointer register is not built.

## Structure
- **Package `mru_pkg`:**
  - `NUM_BTN`=4 and `ID_W`=3.
  - FSM state enum {IDLE, OFFER, GAP}.
  - Function converting a button index to its code (index+1).
- **Sub-module `btn_debounce`:** one instance per button, generated. It contains the synchroniser, debounce counter and stable value, and outputs a 1-cycle rise pulse.
- Tick generator, arbiter and FSM stay in the top module.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=2, `push_ready` tied 1 unless stated otherwise.
- **Reset:** hold `rst`=0 for 5 cycles with `btn`=4'b1111 → all outputs 0. After release, `pending`=4'b0001…4'b1111 appears only after the debounce latency.
- **Single press:** hold `btn[2]` high → one push with `push_id`=3, then `pending`=0. Releasing and re-pressing produces a second push with `push_id`=3.
- **Glitch:** pulse `btn[1]` for 3 cycles (shorter than one tick window) → `pending` stays 0 and no push is issued.
- **Simultaneous presses, `push_ready`=0 throughout:** press all four together → `push_valid` is held with `push_id`=1 and does not change.
  - Then release `push_ready` to 1. With the macro defined, pushes come out as 1,2,3,4, one per tick. With it undefined, the same order results.
- **Round-robin fairness (macro defined):** after a push of 4, press 1 and 3 together → grant order 1 then 3. Re-press 1 immediately → the grant after 3 is 1.
- **Reset mid-OFFER:** assert `rst`=0 while `push_valid`=1 → `push_valid`=0 and `push_id`=0 immediately. After release there is no residual push.
